// File: rtl/accel_pkg.sv
// Shared types and sizing helpers for the accelerometer tilt filter.
package accel_pkg;

   // Width of one raw or filtered tilt value (two's complement).
   localparam int TILT_W = 9;

   // Filter sequencing states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      DIVIDE  = 2'd2,
      PUBLISH = 2'd3
   } state_t;

   // An accumulator holding 2^avg_log2 signed TILT_W samples needs
   // avg_log2 extra bits of headroom above the sample width.
   function automatic int acc_width(input int avg_log2);
      return TILT_W + avg_log2;
   endfunction

endpackage

// File: rtl/accel_axis_avg.sv
// One axis of the tilt filter: sums 2^AVG_LOG2 samples, divides by
// arithmetic shift (floor), applies a symmetric deadzone and holds the
// result until the next load.
module accel_axis_avg
   import accel_pkg::*;
#(
   parameter int AVG_LOG2 = 4,
   parameter int DEADZONE = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sample_en,
   input  logic              acc_clr,
   input  logic              load_en,
   input  logic [TILT_W-1:0] sample_in,
   output logic [TILT_W-1:0] avg_out
);

   localparam int ACC_W = acc_width(AVG_LOG2);

   // Deadzone bounds expressed at accumulator width so the compare is a
   // plain signed compare with no implicit widening.
   localparam logic signed [ACC_W-1:0] DZ_POS = ACC_W'(DEADZONE);
   localparam logic signed [ACC_W-1:0] DZ_NEG = -DZ_POS;

   generate
      if (AVG_LOG2 < 1 || AVG_LOG2 > 6) begin : g_bad_avg_log2
         $error("accel_axis_avg: AVG_LOG2 must be in 1..6");
      end
      if (DEADZONE < 0 || DEADZONE > 255) begin : g_bad_deadzone
         $error("accel_axis_avg: DEADZONE must be in 0..255");
      end
   endgenerate

   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  sample_ext;
   logic signed [ACC_W-1:0]  avg;
   logic signed [TILT_W-1:0] result;
   logic        [TILT_W-1:0] avg_q;

   assign sample_ext = {{AVG_LOG2{sample_in[TILT_W-1]}}, sample_in};

   // Arithmetic shift of a signed sum rounds toward minus infinity.
   assign avg = acc_q >>> AVG_LOG2;

   // Deadzone: small magnitudes collapse to zero; everything else passes
   // through untouched, so the most negative value needs no special case.
   always_comb begin
      // NOTE: assign every always_comb output a default first so no path
      // leaves it unassigned, which would infer a latch.
      result = avg[TILT_W-1:0];
      if ((avg >= DZ_NEG) && (avg <= DZ_POS)) begin
         result = '0;
      end
   end

   // Running per-axis sum of sign-extended samples.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register updates from values sampled before the edge.
      if (reset) begin
         acc_q <= '0;
      end else if (acc_clr) begin
         acc_q <= '0;
      end else if (sample_en) begin
         acc_q <= acc_q + sample_ext;
      end
   end

   // Output register: loads the filtered average, otherwise holds.
   always_ff @(posedge clock) begin
      if (reset) begin
         avg_q <= '0;
      end else if (load_en) begin
         avg_q <= result;
      end
   end

   assign avg_out = avg_q;

endmodule

// File: rtl/accel_tilt_filter.sv
// Accelerometer tilt filter: prescaled sampling of X/Y tilt, block
// averaging over 2^AVG_LOG2 samples with a deadzone, and a one-cycle
// valid pulse on each new filtered pair.
module accel_tilt_filter
   import accel_pkg::*;
#(
   parameter int SAMPLE_DIV = 50000,
   parameter int AVG_LOG2   = 4,
   parameter int DEADZONE   = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [TILT_W-1:0] accel_x_in,
   input  logic [TILT_W-1:0] accel_y_in,
   output logic [TILT_W-1:0] tilt_x,
   output logic [TILT_W-1:0] tilt_y,
   output logic              tilt_valid
);

   // A divider of at least 4 keeps the next tick clear of DIVIDE and
   // PUBLISH, so the FSM never has to drop a sample.
   generate
      if (SAMPLE_DIV < 4) begin : g_bad_sample_div
         $error("accel_tilt_filter: SAMPLE_DIV must be 4 or more");
      end
   endgenerate

   localparam int                   DIV_W    = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [AVG_LOG2-1:0]  CNT_LAST = '1;

   logic [DIV_W-1:0]    div_q;
   logic                tick;
   logic [AVG_LOG2-1:0] cnt_q;
   logic [AVG_LOG2-1:0] cnt_d;
   state_t              state_q;
   state_t              state_d;
   logic                sample_en;
   logic                acc_clr;
   logic                load_en;

   // Sample-rate prescaler: free-runs while enabled, parks at 0 otherwise.
   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         div_q <= '0;
      end else if (div_q == DIV_LAST) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   assign tick = enable && (div_q == DIV_LAST);

   // State and sample-counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath control; enable low returns to IDLE from
   // anywhere and discards any partial block.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sample_en = 1'b0;
      acc_clr   = 1'b0;
      load_en   = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         acc_clr = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ACCUM;
            end
            ACCUM: begin
               if (tick) begin
                  sample_en = 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     state_d = DIVIDE;
                  end else begin
                     cnt_d = cnt_q + AVG_LOG2'(1);
                  end
               end
            end
            DIVIDE: begin
               // Loading here makes the new values and the pulse visible
               // together during the PUBLISH cycle.
               load_en = 1'b1;
               state_d = PUBLISH;
            end
            PUBLISH: begin
               acc_clr = 1'b1;
               state_d = ACCUM;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Valid pulse register, high for the single PUBLISH cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         tilt_valid <= 1'b0;
      end else begin
         tilt_valid <= load_en;
      end
   end

   accel_axis_avg #(
      .AVG_LOG2 (AVG_LOG2),
      .DEADZONE (DEADZONE)
   ) u_axis_x (
      .clock     (clock),
      .reset     (reset),
      .sample_en (sample_en),
      .acc_clr   (acc_clr),
      .load_en   (load_en),
      .sample_in (accel_x_in),
      .avg_out   (tilt_x)
   );

   accel_axis_avg #(
      .AVG_LOG2 (AVG_LOG2),
      .DEADZONE (DEADZONE)
   ) u_axis_y (
      .clock     (clock),
      .reset     (reset),
      .sample_en (sample_en),
      .acc_clr   (acc_clr),
      .load_en   (load_en),
      .sample_in (accel_y_in),
      .avg_out   (tilt_y)
   );

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Self-checking bench for accel_tilt_filter with a queue-based reference
// model of sample ticks, block averaging and the deadzone.
module tb_accel_tilt_filter;

   localparam int SAMPLE_DIV = 4;
   localparam int AVG_LOG2   = 2;
   localparam int DEADZONE   = 8;
   localparam int N_AVG      = 1 << AVG_LOG2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [8:0] accel_x_in = '0;
   logic [8:0] accel_y_in = '0;
   logic [8:0] tilt_x;
   logic [8:0] tilt_y;
   logic       tilt_valid;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   int phase = 0;
   int qx[$];
   int qy[$];
   bit pend = 0;
   int pend_x = 0;
   int pend_y = 0;
   int exp_x = 0;
   int exp_y = 0;
   bit exp_v = 0;

   always #5 clock = ~clock;

   accel_tilt_filter #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .AVG_LOG2   (AVG_LOG2),
      .DEADZONE   (DEADZONE)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .accel_x_in (accel_x_in),
      .accel_y_in (accel_y_in),
      .tilt_x     (tilt_x),
      .tilt_y     (tilt_y),
      .tilt_valid (tilt_valid)
   );

   // Mean of a block rounded toward minus infinity, then deadzoned.
   function automatic int filt(input int sum);
      int a;
      a = (sum >= 0) ? sum / N_AVG : -((-sum + N_AVG - 1) / N_AVG);
      return (a >= -DEADZONE && a <= DEADZONE) ? 0 : a;
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, and
   // return 1 time unit after the edge for sampling.
   task automatic step(input int x, input int y, input bit en, input bit rst);
      int sx;
      int sy;
      @(negedge clock);
      accel_x_in = 9'(x);
      accel_y_in = 9'(y);
      enable     = en;
      reset      = rst;
      @(posedge clock);
      if (rst) begin
         phase = 0; qx.delete(); qy.delete(); pend = 0;
         exp_x = 0; exp_y = 0; exp_v = 0;
      end else if (!en) begin
         phase = 0; qx.delete(); qy.delete(); pend = 0; exp_v = 0;
      end else begin
         exp_v = pend;
         if (pend) begin
            exp_x = pend_x; exp_y = pend_y; pend = 0;
         end
         if (phase % SAMPLE_DIV == SAMPLE_DIV - 1) begin
            qx.push_back(x);
            qy.push_back(y);
            if (qx.size() == N_AVG) begin
               sx = 0; sy = 0;
               foreach (qx[k]) sx += qx[k];
               foreach (qy[k]) sy += qy[k];
               pend_x = filt(sx); pend_y = filt(sy); pend = 1;
               qx.delete(); qy.delete();
            end
         end
         phase++;
      end
      #1;
   endtask

   task automatic do_reset();
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (tilt_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", tilt_valid);
      end
      checks++;
      if (tilt_x !== 9'd0 || tilt_y !== 9'd0) begin
         errors++; $display("FAIL reset_outputs: got x=%0d y=%0d want 0 0",
                            $signed(tilt_x), $signed(tilt_y));
      end
   endtask

   task automatic test_constant();
      int first = -1;
      int second = -1;
      do_reset();
      for (int i = 1; i <= 40; i++) begin
         step(20, -20, 1, 0);
         checks++;
         if ({tilt_valid, tilt_x, tilt_y} !== {exp_v, 9'(exp_x), 9'(exp_y)}) begin
            errors++;
            $display("FAIL constant_model cycle %0d: got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d",
                     i, tilt_valid, $signed(tilt_x), $signed(tilt_y), exp_v, exp_x, exp_y);
         end
         if (tilt_valid) begin
            if (first < 0) begin
               first = i;
               checks++;
               if ($signed(tilt_x) != 20 || $signed(tilt_y) != -20) begin
                  errors++; $display("FAIL constant_value: got x=%0d y=%0d want 20 -20",
                                     $signed(tilt_x), $signed(tilt_y));
               end
            end else if (second < 0) begin
               second = i;
            end
         end
      end
      checks++;
      if (first != 17) begin
         errors++; $display("FAIL constant_latency: got cycle %0d want 17", first);
      end
      checks++;
      if (second - first != 16) begin
         errors++; $display("FAIL back_to_back_period: got %0d want 16", second - first);
      end
   endtask

   task automatic test_rounding();
      int tbl[8] = '{10, 11, 12, 13, -10, -11, -12, -13};
      int want[2] = '{11, -12};
      int npulse = 0;
      do_reset();
      for (int i = 1; i <= 33; i++) begin
         step(tbl[((i - 1) / 4) % 8], int'($urandom_range(511, 0)) - 256, 1, 0);
         checks++;
         if ({tilt_valid, tilt_x, tilt_y} !== {exp_v, 9'(exp_x), 9'(exp_y)}) begin
            errors++;
            $display("FAIL rounding_model cycle %0d: got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d",
                     i, tilt_valid, $signed(tilt_x), $signed(tilt_y), exp_v, exp_x, exp_y);
         end
         if (tilt_valid && npulse < 2) begin
            checks++;
            if ($signed(tilt_x) != want[npulse]) begin
               errors++; $display("FAIL rounding_value %0d: got %0d want %0d",
                                  npulse, $signed(tilt_x), want[npulse]);
            end
            npulse++;
         end
      end
      checks++;
      if (npulse != 2) begin
         errors++; $display("FAIL rounding_pulses: got %0d want 2", npulse);
      end
   endtask

   task automatic test_deadzone();
      int vals[4]  = '{8, -8, 9, -9};
      int wantx[4] = '{0, 0, 9, -9};
      int wanty[4] = '{0, 0, -9, 9};
      for (int k = 0; k < 4; k++) begin
         do_reset();
         for (int i = 1; i <= 17; i++) begin
            step(vals[k], -vals[k], 1, 0);
            checks++;
            if ({tilt_valid, tilt_x, tilt_y} !== {exp_v, 9'(exp_x), 9'(exp_y)}) begin
               errors++;
               $display("FAIL deadzone_model in=%0d cycle %0d: got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d",
                        vals[k], i, tilt_valid, $signed(tilt_x), $signed(tilt_y), exp_v, exp_x, exp_y);
            end
         end
         checks++;
         if (tilt_valid !== 1'b1 || $signed(tilt_x) != wantx[k] || $signed(tilt_y) != wanty[k]) begin
            errors++;
            $display("FAIL deadzone_value in=%0d: got v=%b x=%0d y=%0d want v=1 x=%0d y=%0d",
                     vals[k], tilt_valid, $signed(tilt_x), $signed(tilt_y), wantx[k], wanty[k]);
         end
      end
   endtask

   task automatic test_extremes();
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         step(-256, 255, 1, 0);
         checks++;
         if ({tilt_valid, tilt_x, tilt_y} !== {exp_v, 9'(exp_x), 9'(exp_y)}) begin
            errors++;
            $display("FAIL extremes_model cycle %0d: got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d",
                     i, tilt_valid, $signed(tilt_x), $signed(tilt_y), exp_v, exp_x, exp_y);
         end
      end
      checks++;
      if (tilt_valid !== 1'b1 || $signed(tilt_x) != -256 || $signed(tilt_y) != 255) begin
         errors++; $display("FAIL extremes_value: got v=%b x=%0d y=%0d want v=1 x=-256 y=255",
                            tilt_valid, $signed(tilt_x), $signed(tilt_y));
      end
   endtask

   task automatic test_reset_mid();
      int pulse_at = -1;
      do_reset();
      for (int i = 1; i <= 24; i++) step(100, 100, 1, 0);
      checks++;
      if ($signed(tilt_x) != 100) begin
         errors++; $display("FAIL reset_mid_before: got %0d want 100", $signed(tilt_x));
      end
      step(40, 40, 1, 1);
      for (int j = 1; j <= 17; j++) begin
         step(40, 40, 1, 0);
         if (tilt_valid && pulse_at < 0) pulse_at = j;
         checks++;
         if (pulse_at < 0 && tilt_x !== 9'd0) begin
            errors++; $display("FAIL reset_mid_zero cycle %0d: got %0d want 0", j, $signed(tilt_x));
         end else if (pulse_at > 0 && $signed(tilt_x) != 40) begin
            errors++; $display("FAIL reset_mid_value: got %0d want 40", $signed(tilt_x));
         end
      end
      checks++;
      if (pulse_at != 17) begin
         errors++; $display("FAIL reset_mid_latency: got cycle %0d want 17", pulse_at);
      end
   endtask

   task automatic test_enable_drop();
      int pulses = 0;
      int pulse_at = -1;
      do_reset();
      for (int i = 1; i <= 28; i++) step(50, -50, 1, 0);
      for (int i = 1; i <= 5; i++) begin
         step(-100, 100, 0, 0);
         if (tilt_valid) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++; $display("FAIL enable_drop_pulse: got %0d pulses want 0", pulses);
      end
      checks++;
      if ($signed(tilt_x) != 50 || $signed(tilt_y) != -50) begin
         errors++; $display("FAIL enable_drop_hold: got x=%0d y=%0d want 50 -50",
                            $signed(tilt_x), $signed(tilt_y));
      end
      for (int j = 1; j <= 20; j++) begin
         step(-100, 100, 1, 0);
         checks++;
         if ({tilt_valid, tilt_x, tilt_y} !== {exp_v, 9'(exp_x), 9'(exp_y)}) begin
            errors++;
            $display("FAIL enable_drop_model cycle %0d: got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d",
                     j, tilt_valid, $signed(tilt_x), $signed(tilt_y), exp_v, exp_x, exp_y);
         end
         if (tilt_valid && pulse_at < 0) pulse_at = j;
      end
      checks++;
      if (pulse_at != 17) begin
         errors++; $display("FAIL enable_drop_reenable: got cycle %0d want 17", pulse_at);
      end
   endtask

   task automatic test_random();
      bit en;
      bit rst;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         en  = ($urandom_range(59, 0) != 0);
         rst = ($urandom_range(249, 0) == 0);
         step(int'($urandom_range(511, 0)) - 256, int'($urandom_range(511, 0)) - 256, en, rst);
         checks++;
         if ({tilt_valid, tilt_x, tilt_y} !== {exp_v, 9'(exp_x), 9'(exp_y)}) begin
            errors++;
            $display("FAIL random_model cycle %0d: got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d",
                     i, tilt_valid, $signed(tilt_x), $signed(tilt_y), exp_v, exp_x, exp_y);
         end
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_rounding();
      test_deadzone();
      test_extremes();
      test_reset_mid();
      test_enable_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
